// File: rtl/iod_eye_trainer_pkg.sv
// ============================================================================
// Module : iod_eye_trainer_pkg
// Brief  : Shared state encoding and counter sizing for the eye-width trainer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iod_eye_trainer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    EVAL   = 3'd4,
    FIN    = 3'd5
  } state_t;

  // Width needed to hold the longer of the two phase counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/iod_eye_lane_tracker.sv
// ============================================================================
// Module : iod_eye_lane_tracker
// Brief  : Per-lane hit accumulator, freeze bit and eye-width result registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iod_eye_lane_tracker #(
  parameter int WIDTH_W   = 3,
  parameter int MAX_WIDTH = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_hit_i,
  input  logic               sample_i,
  input  logic               flag_i,
  input  logic               eval_i,
  input  logic               fin_i,
  input  logic [WIDTH_W-1:0] width_i,
  output logic               hit_o,
  output logic               frozen_o,
  output logic [WIDTH_W-1:0] eye_width_o,
  output logic               fail_o,
  output logic               open_o
);

  logic               hit_q;
  logic               frozen_q;
  logic [WIDTH_W-1:0] eye_q;
  logic               fail_q;
  logic               open_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q    <= 1'b0;
      frozen_q <= 1'b0;
      eye_q    <= '0;
      fail_q   <= 1'b0;
      open_q   <= 1'b0;
    end else begin
      if (start_i) begin
        hit_q    <= 1'b0;
        frozen_q <= 1'b0;
        eye_q    <= '0;
        fail_q   <= 1'b0;
        open_q   <= 1'b0;
      end
      if (clr_hit_i) begin
        hit_q <= 1'b0;
      end else if (sample_i && !frozen_q) begin
        hit_q <= hit_q | flag_i;
      end
      // The last clean width is the one before the first flagged step.
      if (eval_i && !frozen_q && hit_q) begin
        frozen_q <= 1'b1;
        if (width_i == '0) begin
          fail_q <= 1'b1;
          eye_q  <= '0;
        end else begin
          eye_q  <= width_i - 1'b1;
        end
      end
      if (fin_i && !frozen_q) begin
        eye_q  <= WIDTH_W'(MAX_WIDTH);
        open_q <= 1'b1;
      end
    end
  end

  assign hit_o       = hit_q;
  assign frozen_o    = frozen_q;
  assign eye_width_o = eye_q;
  assign fail_o      = fail_q;
  assign open_o      = open_q;

endmodule

`default_nettype wire

// File: rtl/iod_eye_width_trainer.sv
// ============================================================================
// Module : iod_eye_width_trainer
// Brief  : Sweeps the IOD eye-monitor width over NUM_LANES lanes and records
//          each lane's open-eye width. Option: IOD_EYE_FLAG_SYNC_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iod_eye_width_trainer
  import iod_eye_trainer_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int WIDTH_W       = 3,
  parameter int MAX_WIDTH     = 7,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64
) (
  input  logic                           FAB_CLK,
  input  logic                           RX_SYNC_RST,
  input  logic                           START,
  input  logic [NUM_LANES-1:0]           EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]           EYE_MONITOR_LATE,
  output logic [WIDTH_W-1:0]             EYE_MONITOR_LANE_WIDTH,
  output logic [NUM_LANES-1:0]           EYE_MONITOR_CLEAR_FLAGS,
  output logic                           BUSY,
  output logic                           DONE,
  output logic [NUM_LANES*WIDTH_W-1:0]   EYE_WIDTH,
  output logic [NUM_LANES-1:0]           LANE_FAIL,
  output logic [NUM_LANES-1:0]           LANE_OPEN
);

  logic [NUM_LANES-1:0] flag;

`ifdef IOD_EYE_FLAG_SYNC_EN
  localparam int SYNC_EXTRA = 2;
  logic [NUM_LANES-1:0] early_s1_q, early_s2_q, late_s1_q, late_s2_q;

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      early_s1_q <= '0;
      early_s2_q <= '0;
      late_s1_q  <= '0;
      late_s2_q  <= '0;
    end else begin
      early_s1_q <= EYE_MONITOR_EARLY;
      early_s2_q <= early_s1_q;
      late_s1_q  <= EYE_MONITOR_LATE;
      late_s2_q  <= late_s1_q;
    end
  end

  assign flag = early_s2_q | late_s2_q;
`else
  localparam int SYNC_EXTRA = 0;
  assign flag = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
`endif

  localparam int SETTLE_EFF = SETTLE_CYCLES + SYNC_EXTRA;
  localparam int CNT_W      = cnt_width(SETTLE_EFF, SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [CNT_W-1:0]   SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [WIDTH_W-1:0] WIDTH_LAST  = WIDTH_W'(MAX_WIDTH);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH_W-1:0]   width_q;
  logic [NUM_LANES-1:0] clear_q;
  logic                 busy_q;
  logic                 done_q;

  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] frozen;
  logic                 accept;

  assign accept = (state_q == IDLE) && START;

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      clear_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clear_q <= '0;
          if (START) begin
            state_q <= CLEAR;
            width_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            clear_q <= '1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          clear_q <= '0;
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q   <= '0;
            state_q <= EVAL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        EVAL: begin
          // A lane hit this step freezes at this EVAL, so count it as frozen.
          if ((&(frozen | hit)) || (width_q == WIDTH_LAST)) begin
            state_q <= FIN;
          end else begin
            width_q <= width_q + 1'b1;
            clear_q <= '1;
            state_q <= CLEAR;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          clear_q <= '0;
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      iod_eye_lane_tracker #(
        .WIDTH_W   (WIDTH_W),
        .MAX_WIDTH (MAX_WIDTH)
      ) u_tracker (
        .clk_i       (FAB_CLK),
        .rst_i       (RX_SYNC_RST),
        .start_i     (accept),
        .clr_hit_i   (state_q == CLEAR),
        .sample_i    (state_q == SAMPLE),
        .flag_i      (flag[g]),
        .eval_i      (state_q == EVAL),
        .fin_i       (state_q == FIN),
        .width_i     (width_q),
        .hit_o       (hit[g]),
        .frozen_o    (frozen[g]),
        .eye_width_o (EYE_WIDTH[g*WIDTH_W +: WIDTH_W]),
        .fail_o      (LANE_FAIL[g]),
        .open_o      (LANE_OPEN[g])
      );
    end
  endgenerate

  assign EYE_MONITOR_LANE_WIDTH  = width_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;

endmodule

`default_nettype wire
